// File: rtl/nonce_sweep_ctrl_if.sv
// nonce_sweep_ctrl_if: job handshake, pipeline launch/result and status signals of the nonce sweep controller.
interface nonce_sweep_ctrl_if #(
    parameter int WARR_S = 512
);
    logic              job_valid;
    logic              job_ready;
    logic [WARR_S-1:0] job_block;
    logic [31:0]       job_nonce_first;
    logic [31:0]       job_nonce_last;
    logic              abort;
    logic              pipe_en;
    logic [WARR_S-1:0] pipe_W;
    logic              pipe_done;
    logic              pipe_hit;
    logic              found_valid;
    logic [31:0]       found_nonce;
    logic              sweep_done;
    logic              busy;
    logic              err;

    modport master (
        output job_valid, job_block, job_nonce_first, job_nonce_last, abort, pipe_done, pipe_hit,
        input  job_ready, pipe_en, pipe_W, found_valid, found_nonce, sweep_done, busy, err
    );

    modport slave (
        input  job_valid, job_block, job_nonce_first, job_nonce_last, abort, pipe_done, pipe_hit,
        output job_ready, pipe_en, pipe_W, found_valid, found_nonce, sweep_done, busy, err
    );
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: sweeps an inclusive nonce range into the SHA pipeline, one launch every DELAY cycles,
// tracking in-flight work and attributing in-order results back to nonces.
module nonce_sweep_ctrl #(
    parameter int WARR_S      = 512,
    parameter int DELAY       = 20,
    parameter int NONCE_LSB   = 384,
    parameter int MAX_INFL    = 127,
    parameter bit STOP_ON_HIT = 1'b1
) (
    input logic               clk,
    input logic               reset,
    nonce_sweep_ctrl_if.slave bus
);
    localparam int IW = $clog2(MAX_INFL + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [WARR_S-1:0] block;
    logic [WARR_S-1:0] nonce_w;
    logic [31:0]       first;
    logic [31:0]       last;
    logic [31:0]       cur;
    logic [31:0]       done_cnt;
    logic [4:0]        ic;
    logic [IW-1:0]     inflight;
    logic              counted;
    logic              spurious;
    logic              launch;
    logic              stop;
    logic              accept;
    logic              bad_range;

    always_comb begin
        counted   = bus.pipe_done && inflight != '0;
        spurious  = bus.pipe_done && inflight == '0;
        launch    = state == ISSUE && ic == '0 && inflight != IW'(MAX_INFL) && !bus.abort;
        stop      = bus.abort || (STOP_ON_HIT && counted && bus.pipe_hit);
        accept    = state == IDLE && bus.job_valid && bus.job_ready;
        bad_range = bus.job_nonce_last < bus.job_nonce_first;
        nonce_w   = block;
        nonce_w[NONCE_LSB +: 32] = cur;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            block           <= '0;
            first           <= '0;
            last            <= '0;
            cur             <= '0;
            done_cnt        <= '0;
            ic              <= '0;
            inflight        <= '0;
            bus.job_ready   <= 1'b0;
            bus.pipe_en     <= 1'b0;
            bus.pipe_W      <= '0;
            bus.found_valid <= 1'b0;
            bus.found_nonce <= '0;
            bus.sweep_done  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.pipe_en     <= launch;
            bus.found_valid <= counted && bus.pipe_hit;
            bus.sweep_done  <= 1'b0;
            inflight        <= inflight + IW'(launch) - IW'(counted);
            if (launch)
                bus.pipe_W <= nonce_w;
            if (counted) begin
                done_cnt <= done_cnt + 32'd1;
                if (bus.pipe_hit)
                    bus.found_nonce <= first + done_cnt;
            end
            if (spurious)
                bus.err <= 1'b1;
            case (state)
                IDLE: begin
                    bus.job_ready <= !accept;
                    if (accept) begin
                        block          <= bus.job_block;
                        first          <= bus.job_nonce_first;
                        last           <= bus.job_nonce_last;
                        cur            <= bus.job_nonce_first;
                        done_cnt       <= '0;
                        ic             <= '0;
                        bus.err        <= bad_range;
                        bus.busy       <= 1'b1;
                        bus.sweep_done <= bad_range;
                        state          <= bad_range ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    // ic parks at 0 while a launch is withheld, so spacing restarts from the actual launch
                    ic <= (ic != '0 || launch) ? ((ic == 5'(DELAY - 1)) ? 5'd0 : ic + 5'd1) : ic;
                    if (launch && cur != last)
                        cur <= cur + 32'd1;
                    if (stop || (launch && cur == last))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        bus.sweep_done <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: begin
                    bus.job_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb_nonce_sweep_ctrl: directed checks of the nonce sweep controller against a fixed-latency pipeline model.
module tb_nonce_sweep_ctrl;
    localparam int DELAY = 4;
    localparam int L     = DELAY * 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    int           compared   = 0;
    int           mismatched = 0;
    int           cyc = 0;
    logic [31:0]  hist = '0;
    logic         spur = 1'b0;
    int           res_idx = 0;
    int           hit_idx = -1;
    logic [511:0] blk;
    logic [511:0] expw;
    int           n_launch, n_found, done_at, last_done_at, first_launch_at, last_launch_at, gap_bad;
    logic [31:0]  found_n;
    logic         err_at_done;

    nonce_sweep_ctrl_if #(.WARR_S(512)) bus ();

    nonce_sweep_ctrl #(
        .WARR_S(512), .DELAY(DELAY), .NONCE_LSB(384), .MAX_INFL(127), .STOP_ON_HIT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; the pipeline model returns every launch exactly L cycles later, in order
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        hist          = {hist[30:0], bus.pipe_en};
        bus.pipe_done = hist[L] | spur;
        bus.pipe_hit  = hist[L] && res_idx == hit_idx;
        if (hist[L])
            res_idx++;
    endtask

    task automatic sweep(input logic [31:0] f, input logic [31:0] l, input int hit, input int abort_at);
        int budget = 0;
        n_launch = 0; n_found = 0; done_at = -1; last_done_at = -1;
        first_launch_at = -1; last_launch_at = -1; gap_bad = 0; found_n = '0;
        res_idx = 0; hit_idx = hit; err_at_done = 1'bx;
        while (!bus.job_ready && budget < 50) begin
            tick();
            budget++;
        end
        check("job_ready_wait", bus.job_ready, 1);
        bus.job_valid = 1'b1; bus.job_block = blk; bus.job_nonce_first = f; bus.job_nonce_last = l;
        tick();
        cyc = 0;
        bus.job_valid = 1'b0; bus.job_block = ~blk; bus.job_nonce_first = 32'h0BAD; bus.job_nonce_last = 32'h0BAD;
        while (done_at < 0 && cyc < 2000) begin
            if (bus.pipe_en) begin
                expw = blk;
                expw[384 +: 32] = f + n_launch;
                compared++;
                assert (bus.pipe_W === expw) else begin
                    mismatched++;
                    $error("FAIL pipe_W launch %0d: observed %0h expected %0h", n_launch, bus.pipe_W[415:384], expw[415:384]);
                end
                if (last_launch_at >= 0 && cyc - last_launch_at != DELAY)
                    gap_bad++;
                if (first_launch_at < 0)
                    first_launch_at = cyc;
                last_launch_at = cyc;
                n_launch++;
            end
            if (bus.pipe_done)
                last_done_at = cyc;
            if (bus.found_valid) begin
                n_found++;
                found_n = bus.found_nonce;
            end
            if (bus.sweep_done) begin
                done_at     = cyc;
                err_at_done = bus.err;
            end else begin
                if (cyc == abort_at)
                    bus.abort = 1'b1;
                tick();
            end
        end
        check("sweep_done_seen", done_at >= 0, 1);
        bus.abort = 1'b0;
        tick();
        check("sweep_done_one_cycle", bus.sweep_done, 0);
        check("job_ready_after_done", bus.job_ready, 1);
        check("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        blk = {8{64'h0123_4567_89AB_CDEF}};
        bus.job_valid = 1'b0; bus.job_block = '0; bus.job_nonce_first = '0; bus.job_nonce_last = '0;
        bus.abort = 1'b0; bus.pipe_done = 1'b0; bus.pipe_hit = 1'b0;

        // reset held for 5 cycles
        repeat (5) tick();
        check("rst_job_ready", bus.job_ready, 0);
        check("rst_pipe_en", bus.pipe_en, 0);
        check("rst_pipe_W", bus.pipe_W[415:352], 0);
        check("rst_found_valid", bus.found_valid, 0);
        check("rst_found_nonce", bus.found_nonce, 0);
        check("rst_sweep_done", bus.sweep_done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b1;
        #1;
        check("rst_release_ready_low", bus.job_ready, 0);
        tick();
        check("rst_release_ready", bus.job_ready, 1);
        check("rst_release_busy", bus.busy, 0);

        // 0x10..0x14, no hits
        sweep(32'h10, 32'h14, -1, -1);
        check("t2_launches", n_launch, 5);
        check("t2_first_launch", first_launch_at, 1);
        check("t2_last_launch", last_launch_at, 17);
        check("t2_spacing", gap_bad, 0);
        check("t2_last_result", last_done_at, 33);
        check("t2_done_after_drain", (done_at - last_done_at >= 1) && (done_at - last_done_at <= 2), 1);
        check("t2_found", n_found, 0);
        check("t2_err", err_at_done, 0);

        // 0x10..0x1F, 3rd result hits: launches stop at cycle 25, later results still drain
        sweep(32'h10, 32'h1F, 2, -1);
        check("t3_found_cnt", n_found, 1);
        check("t3_found_nonce", found_n, 32'h12);
        check("t3_launches", n_launch, 7);
        check("t3_last_launch", last_launch_at, 25);
        check("t3_last_result", last_done_at, 41);
        check("t3_done_after_drain", done_at > last_done_at, 1);

        // top of the nonce space
        sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, -1);
        check("t4_top_launches", n_launch, 2);
        check("t4_top_err", err_at_done, 0);

        // empty range
        sweep(32'h5, 32'h4, -1, -1);
        check("t4_bad_launches", n_launch, 0);
        check("t4_bad_err", err_at_done, 1);
        check("t4_bad_done_at", done_at, 0);
        check("t4_err_sticky", bus.err, 1);

        // abort raised so the edge that would launch at cycle 33 sees it
        sweep(32'h100, 32'h163, -1, 32);
        check("t5_launches", n_launch, 8);
        check("t5_last_launch", last_launch_at, 29);
        check("t5_last_result", last_done_at, 45);
        check("t5_done_after_drain", done_at > last_done_at, 1);
        check("t5_err_cleared", err_at_done, 0);

        // spurious result while idle
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        check("t6_spur_err", bus.err, 1);
        check("t6_spur_busy", bus.busy, 0);
        sweep(32'h0, 32'h1, -1, -1);
        check("t6_after_spur_launches", n_launch, 2);
        check("t6_after_spur_err", err_at_done, 0);

        // reset in the middle of ISSUE, on a launch cycle
        bus.job_valid = 1'b1; bus.job_block = blk; bus.job_nonce_first = 32'h40; bus.job_nonce_last = 32'h60;
        tick();
        cyc = 0;
        bus.job_valid = 1'b0;
        repeat (5) tick();
        check("t6_pre_reset_launch", bus.pipe_en, 1);
        reset = 1'b0;
        #1;
        check("t6_reset_pipe_en", bus.pipe_en, 0);
        check("t6_reset_busy", bus.busy, 0);
        check("t6_reset_job_ready", bus.job_ready, 0);
        hist = '0;
        bus.pipe_done = 1'b0;
        bus.pipe_hit = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t6_release_job_ready", bus.job_ready, 1);
        check("t6_release_busy", bus.busy, 0);
        sweep(32'h20, 32'h21, -1, -1);
        check("t6_post_reset_launches", n_launch, 2);
        check("t6_post_reset_err", err_at_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
